bus_autoclear_timeout: RTL and testbench

BUS_AUTOCLEAR_TIMEOUT -- requirements
Module: Bus_Autoclear_Timeout

---
 rtl/bus_autoclear_timeout.sv | 150 +++++++++++++++
 tb/tb_bus_autoclear_timeout.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_autoclear_timeout.sv
// Register-mapped autoclear launcher: per-channel start level held until the
// client reports done, software aborts, or a programmable timeout expires.
module bus_autoclear_timeout #(
  parameter int g_CHANNELS      = 2,
  parameter int g_TIMEOUT_WIDTH = 16
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  input  logic                  i_Bus_CS,
  input  logic                  i_Bus_Wr_Rd_n,
  input  logic [4:0]            i_Bus_Addr8,
  input  logic [15:0]           i_Bus_Wr_Data,
  output logic [15:0]           o_Bus_Rd_Data,
  output logic                  o_Bus_Rd_DV,
  output logic [g_CHANNELS-1:0] o_Start,
  input  logic [g_CHANNELS-1:0] i_Done,
  output logic                  o_Irq
);

  localparam int C  = g_CHANNELS;
  localparam int TW = g_TIMEOUT_WIDTH;
  // Data width wide enough to hold the timeout-enable field at bit 8.
  localparam int EW = (C + 8 > 16) ? C + 8 : 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  // Bus protocol: an access is one cycle with i_Bus_CS high; a write commits on
  // that edge, a read returns data with o_Bus_Rd_DV high exactly one cycle later.
  logic          wr_en, rd_en;
  logic [3:0]    reg_sel;
  logic [EW-1:0] wr_ext;
  logic          unused_addr_lsb;

  assign wr_en           = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_en           = i_Bus_CS & ~i_Bus_Wr_Rd_n;
  assign reg_sel         = i_Bus_Addr8[4:1];
  assign wr_ext          = EW'(i_Bus_Wr_Data);
  assign unused_addr_lsb = i_Bus_Addr8[0];

  logic [C-1:0]  start_mask, stop_mask, clr_mask;
  logic [C-1:0]  done_set, to_set;
  logic [C-1:0]  done_hist_q, to_hist_q;
  logic [C-1:0]  irq_en_done_q, irq_en_to_q;
  logic [TW-1:0] timeout_val_q;

  assign start_mask = (wr_en && reg_sel == 4'h0) ? wr_ext[C-1:0] : '0;
  assign stop_mask  = (wr_en && reg_sel == 4'h2) ? wr_ext[C-1:0] : '0;
  assign clr_mask   = (wr_en && reg_sel == 4'h4) ? wr_ext[C-1:0] : '0;

  for (genvar n = 0; n < C; n++) begin : g_chan
    chan_state_t   state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          hit_to, set_done, set_to;

    // cnt_inc is the number of RUN cycles including the current one.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign hit_to  = (timeout_val_q != '0) && (cnt_inc == timeout_val_q);

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      set_done = 1'b0;
      set_to   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_mask[n]) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_inc;
          if (stop_mask[n]) begin
            state_d = ST_IDLE;
          end else if (i_Done[n]) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
          end else if (hit_to) begin
            state_d = ST_IDLE;
            set_to  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign o_Start[n]  = (state_q == ST_RUN);
    assign done_set[n] = set_done;
    assign to_set[n]   = set_to;
  end

  logic [EW-1:0] rd_ext;

  always_comb begin
    rd_ext = '0;
    case (reg_sel)
      4'h1: rd_ext[C-1:0] = o_Start;
      4'h3: rd_ext[C-1:0] = done_hist_q;
      4'h5: rd_ext[C-1:0] = to_hist_q;
      4'h6: begin
        // With more than 8 channels the two enable fields overlap on readback.
        rd_ext[C-1:0] = irq_en_done_q;
        rd_ext[8 +: C] = rd_ext[8 +: C] | irq_en_to_q;
      end
      4'h7: rd_ext[TW-1:0] = timeout_val_q;
      default: rd_ext = '0;
    endcase
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      done_hist_q   <= '0;
      to_hist_q     <= '0;
      irq_en_done_q <= '0;
      irq_en_to_q   <= '0;
      timeout_val_q <= '0;
      o_Irq         <= 1'b0;
      o_Bus_Rd_DV   <= 1'b0;
      o_Bus_Rd_Data <= '0;
    end else begin
      // A set in the same cycle as a clear wins.
      done_hist_q <= (done_hist_q & ~clr_mask) | done_set;
      to_hist_q   <= (to_hist_q & ~clr_mask) | to_set;
      if (wr_en && reg_sel == 4'h6) begin
        irq_en_done_q <= wr_ext[C-1:0];
        irq_en_to_q   <= wr_ext[8 +: C];
      end
      if (wr_en && reg_sel == 4'h7) begin
        timeout_val_q <= wr_ext[TW-1:0];
      end
      o_Irq         <= |((done_hist_q & irq_en_done_q) | (to_hist_q & irq_en_to_q));
      o_Bus_Rd_DV   <= rd_en;
      o_Bus_Rd_Data <= rd_en ? rd_ext[15:0] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_bus_autoclear_timeout.sv
// Bench for bus_autoclear_timeout: register table, directed multi-cycle
// sequences, then random traffic against a cycle-count reference model.
module tb_bus_autoclear_timeout;

  localparam int C = 2;

  logic          r_Bus_Clk   = 1'b0;
  logic          r_Bus_Rst_L = 1'b1;
  logic          bus_cs      = 1'b0;
  logic          bus_wr      = 1'b0;
  logic [4:0]    bus_addr    = '0;
  logic [15:0]   bus_wdata   = '0;
  logic [C-1:0]  done        = '0;
  logic [15:0]   rd_data;
  logic          rd_dv;
  logic [C-1:0]  start;
  logic          irq;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 r_Bus_Clk = ~r_Bus_Clk;

  bus_autoclear_timeout #(.g_CHANNELS(C), .g_TIMEOUT_WIDTH(16)) dut (
    .i_Bus_Clk     (r_Bus_Clk),
    .i_Bus_Rst_L   (r_Bus_Rst_L),
    .i_Bus_CS      (bus_cs),
    .i_Bus_Wr_Rd_n (bus_wr),
    .i_Bus_Addr8   (bus_addr),
    .i_Bus_Wr_Data (bus_wdata),
    .o_Bus_Rd_Data (rd_data),
    .o_Bus_Rd_DV   (rd_dv),
    .o_Start       (start),
    .i_Done        (done),
    .o_Irq         (irq)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge r_Bus_Clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_cs = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [15:0] d);
    bus_cs = 1'b1; bus_wr = 1'b0; bus_addr = a;
    tick();
    bus_cs = 1'b0;
    d = rd_data;
    check("rd_dv_high", rd_dv, 1'b1);
  endtask

  task automatic read_expect(input string name, input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by whether it is running and how many RUN
  // cycles it has completed; a timeout fires on the RUN cycle whose ordinal
  // equals TIMEOUT_VAL.
  bit          m_run[C];
  int          m_age[C];
  logic [C-1:0] m_dh, m_th, m_en_d, m_en_t;
  int          m_tov;
  logic        m_irq;

  function automatic void m_reset();
    for (int n = 0; n < C; n++) begin
      m_run[n] = 1'b0;
      m_age[n] = 0;
    end
    m_dh = '0; m_th = '0; m_en_d = '0; m_en_t = '0; m_tov = 0; m_irq = 1'b0;
  endfunction

  function automatic logic [C-1:0] m_run_vec();
    logic [C-1:0] v;
    for (int n = 0; n < C; n++) v[n] = m_run[n];
    return v;
  endfunction

  function automatic logic [15:0] m_read(input logic [4:0] a);
    logic [15:0] r;
    r = '0;
    if (!a[4]) begin
      case (a[3:1])
        3'd1: r[C-1:0] = m_run_vec();
        3'd3: r[C-1:0] = m_dh;
        3'd5: r[C-1:0] = m_th;
        3'd6: begin r[C-1:0] = m_en_d; r[8 +: C] = m_en_t; end
        3'd7: r = 16'(m_tov);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic void m_step(input logic cs, input logic wr, input logic [4:0] a,
                                 input logic [15:0] d, input logic [C-1:0] dn);
    logic wh;
    logic [C-1:0] dset, tset, clr;
    int nc;
    wh = cs && wr && !a[4];
    dset = '0; tset = '0; clr = '0;
    m_irq = |((m_dh & m_en_d) | (m_th & m_en_t));
    for (int n = 0; n < C; n++) begin
      if (m_run[n]) begin
        nc = (m_age[n] >= 65535) ? 65535 : m_age[n] + 1;
        if (wh && a[3:1] == 3'd2 && d[n]) m_run[n] = 1'b0;
        else if (dn[n]) begin m_run[n] = 1'b0; dset[n] = 1'b1; end
        else if (m_tov != 0 && nc == m_tov) begin m_run[n] = 1'b0; tset[n] = 1'b1; end
        else m_age[n] = nc;
      end else if (wh && a[3:1] == 3'd0 && d[n]) begin
        m_run[n] = 1'b1;
        m_age[n] = 0;
      end
    end
    if (wh && a[3:1] == 3'd4) clr = d[C-1:0];
    m_dh = (m_dh & ~clr) | dset;
    m_th = (m_th & ~clr) | tset;
    if (wh && a[3:1] == 3'd6) begin m_en_d = d[C-1:0]; m_en_t = d[8 +: C]; end
    if (wh && a[3:1] == 3'd7) m_tov = int'(d);
  endfunction

  // ---------------- register table ----------------
  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // ---------------- stimulus ----------------
  initial begin
    int high;
    logic [4:0]  a;
    logic [15:0] d;
    logic        cs, wr, exp_dv;
    logic [C-1:0] dn;

    // reset state
    #1 r_Bus_Rst_L = 1'b0;
    #1;
    check("rst_outputs", {rd_dv, rd_data, start, irq}, '0);
    repeat (3) @(posedge r_Bus_Clk);
    @(negedge r_Bus_Clk);
    r_Bus_Rst_L = 1'b1;
    tick();

    for (int i = 0; i < 16; i += 2) vecs.push_back('{1'b0, 5'(i), 16'h0, 16'h0});
    vecs.push_back('{1'b1, 5'h0E, 16'hABCD, 16'h0});
    vecs.push_back('{1'b0, 5'h0E, 16'h0,    16'hABCD});
    vecs.push_back('{1'b1, 5'h0C, 16'hFFFF, 16'h0});
    vecs.push_back('{1'b0, 5'h0C, 16'h0,    16'h0303});
    vecs.push_back('{1'b0, 5'h10, 16'h0,    16'h0000});
    vecs.push_back('{1'b0, 5'h1E, 16'h0,    16'h0000});
    vecs.push_back('{1'b0, 5'h13, 16'h0,    16'h0000});
    vecs.push_back('{1'b1, 5'h12, 16'hFFFF, 16'h0});
    vecs.push_back('{1'b1, 5'h1E, 16'h1111, 16'h0});
    vecs.push_back('{1'b0, 5'h0E, 16'h0,    16'hABCD});
    vecs.push_back('{1'b0, 5'h0C, 16'h0,    16'h0303});
    vecs.push_back('{1'b1, 5'h0F, 16'h0005, 16'h0});
    vecs.push_back('{1'b0, 5'h0E, 16'h0,    16'h0005});
    vecs.push_back('{1'b0, 5'h01, 16'h0,    16'h0000});
    vecs.push_back('{1'b1, 5'h0C, 16'h0000, 16'h0});
    vecs.push_back('{1'b1, 5'h0E, 16'h0000, 16'h0});
    vecs.push_back('{1'b0, 5'h0C, 16'h0,    16'h0000});
    vecs.push_back('{1'b0, 5'h0E, 16'h0,    16'h0000});

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
        tick();
        check($sformatf("vec%0d_dv_low", i), {rd_dv, rd_data}, '0);
      end
    end

    // start ch0, done for two cycles
    bus_write(5'h00, 16'h0001);
    read_expect("a_state_run", 5'h02, 16'h0001);
    done[0] = 1'b1;
    tick(); tick();
    done[0] = 1'b0;
    read_expect("a_done_hist", 5'h06, 16'h0001);
    read_expect("a_state_idle", 5'h02, 16'h0000);

    // history clear, then start/stop ch1
    bus_write(5'h08, 16'h0001);
    read_expect("b_hist_clr", 5'h06, 16'h0000);
    bus_write(5'h00, 16'h0002);
    check("b_start1", start, 2'b10);
    bus_write(5'h04, 16'h0002);
    read_expect("b_state_stop", 5'h02, 16'h0000);
    read_expect("b_no_hist", 5'h06, 16'h0000);

    // timeout of 10 with the timeout interrupt enabled
    bus_write(5'h0C, 16'h0100);
    bus_write(5'h0E, 16'd10);
    bus_write(5'h00, 16'h0001);
    check("c_start_rise", start[0], 1'b1);
    high = 1;
    for (int k = 0; k < 40 && start[0]; k++) begin
      tick();
      if (start[0]) high++;
    end
    check("c_run_len", high, 10);
    check("c_irq_lag", irq, 1'b0);
    tick();
    check("c_irq", irq, 1'b1);
    read_expect("c_to_hist", 5'h0A, 16'h0001);
    bus_write(5'h08, 16'h0003);
    tick();
    check("c_irq_clr", irq, 1'b0);
    bus_write(5'h0C, 16'h0000);

    // done on the timeout cycle wins
    bus_write(5'h00, 16'h0001);
    repeat (9) tick();
    check("d_still_run", start[0], 1'b1);
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("d_stopped", start[0], 1'b0);
    read_expect("d_done_hist", 5'h06, 16'h0001);
    read_expect("d_to_hist", 5'h0A, 16'h0000);
    bus_write(5'h08, 16'h0003);

    // re-start during RUN does not restart the counter
    bus_write(5'h00, 16'h0001);
    high = 1;
    repeat (3) begin
      tick();
      if (start[0]) high++;
    end
    bus_write(5'h00, 16'h0001);
    if (start[0]) high++;
    for (int k = 0; k < 40 && start[0]; k++) begin
      tick();
      if (start[0]) high++;
    end
    check("e_restart_len", high, 10);
    read_expect("e_to_hist", 5'h0A, 16'h0001);
    bus_write(5'h08, 16'h0003);

    // lowering TIMEOUT_VAL below the elapsed count: channel keeps running
    bus_write(5'h00, 16'h0001);
    repeat (5) tick();
    bus_write(5'h0E, 16'd3);
    repeat (20) tick();
    check("g_keeps_run", start[0], 1'b1);
    bus_write(5'h04, 16'h0001);
    check("g_stopped", start[0], 1'b0);
    read_expect("g_to_hist", 5'h0A, 16'h0000);
    read_expect("g_done_hist", 5'h06, 16'h0000);

    // asynchronous reset mid-RUN
    bus_write(5'h00, 16'h0003);
    check("f_both_run", start, 2'b11);
    #3 r_Bus_Rst_L = 1'b0;
    #1;
    check("f_async_drop", start, 2'b00);
    m_reset();
    @(posedge r_Bus_Clk);
    @(negedge r_Bus_Clk);
    r_Bus_Rst_L = 1'b1;
    tick();
    check("f_after_rel", {start, irq}, '0);
    for (int i = 0; i < 16; i += 2) read_expect($sformatf("f_reg%0h", i), 5'(i), 16'h0000);

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cs = ($urandom_range(0, 2) == 0);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 5'($urandom_range(16, 31));
      else a = 5'($urandom_range(0, 15));
      case (a[3:1])
        3'd0, 3'd2: d = 16'($urandom_range(0, 3));
        3'd7:       d = 16'($urandom_range(0, 14));
        default:    d = 16'($urandom);
      endcase
      for (int n = 0; n < C; n++) dn[n] = ($urandom_range(0, 15) == 0);
      exp_dv = cs && !wr;
      if (exp_dv) exp_q.push_back(m_read(a));
      bus_cs = cs; bus_wr = wr; bus_addr = a; bus_wdata = d; done = dn;
      @(posedge r_Bus_Clk);
      m_step(cs, wr, a, d, dn);
      #1;
      check("rnd_start", start, m_run_vec());
      check("rnd_irq", irq, m_irq);
      check("rnd_dv", rd_dv, exp_dv);
      if (rd_dv && exp_q.size() > 0) check("rnd_rd", rd_data, exp_q.pop_front());
      else if (!rd_dv) check("rnd_rd_idle", rd_data, 16'h0000);
    end
    bus_cs = 1'b0; done = '0;
    check("rnd_q_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
